// File: rtl/mult_timing_leak_monitor.sv
// rtl/mult_timing_leak_monitor.sv - N-lane shift-add multiplier timing side-channel monitor
//
// Purpose: runs LANES sequential shift-add multipliers from one shared start and
// compares their completion cycles. A sticky flag reports any lane finishing in a
// different cycle from the others. first_mask records the earliest finishers and
// skew counts the cycles from the first completion to the last.
//
// Ports:
//   clk          in   1              rising-edge clock
//   rst          in   1              synchronous active-high reset
//   start        in   1              start request, sampled only when idle
//   multiplier   in   LANES*WIDTH    lane i operand at [i*WIDTH +: WIDTH]
//   multiplicand in   LANES*WIDTH    lane i operand at [i*WIDTH +: WIDTH]
//   product      out  LANES*2*WIDTH  lane i result at [i*2*WIDTH +: 2*WIDTH]
//   lane_done    out  LANES          per-lane one-cycle completion pulse
//   busy         out  1              high from start acceptance until check_done
//   timing_leak  out  1              sticky: lanes did not all complete together
//   first_mask   out  LANES          lanes that pulsed in the earliest completion cycle
//   skew         out  SKEW_W         saturating first-to-last completion distance
//   check_done   out  1              one-cycle pulse closing the check
module mult_timing_leak_monitor #(
  parameter int WIDTH   = 1024,
  parameter int LANES   = 2,
  parameter int CT_MODE = 1,
  parameter int SKEW_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LANES*WIDTH-1:0]     multiplier,
  input  logic [LANES*WIDTH-1:0]     multiplicand,
  output logic [LANES*2*WIDTH-1:0]   product,
  output logic [LANES-1:0]           lane_done,
  output logic                       busy,
  output logic                       timing_leak,
  output logic [LANES-1:0]           first_mask,
  output logic [SKEW_W-1:0]          skew,
  output logic                       check_done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_RUN    = 2'd1;
  localparam logic [1:0] T_FINISH = 2'd2;

  localparam logic [1:0] L_IDLE = 2'd0;
  localparam logic [1:0] L_RUN  = 2'd1;
  localparam logic [1:0] L_DONE = 2'd2;

  localparam logic [LANES-1:0]  ALL_LANES = {LANES{1'b1}};
  localparam logic [SKEW_W-1:0] SKEW_MAX  = {SKEW_W{1'b1}};

  logic [1:0]        top_q, top_d;
  logic              busy_q, busy_d;
  logic              leak_q, leak_d;
  logic [LANES-1:0]  first_q, first_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic [LANES-1:0]  seen_q, seen_d;
  logic              cdone_q, cdone_d;

  logic [LANES-1:0]  lane_done_w;
  logic [LANES-1:0]  seen_now;
  logic              start_acc;
  logic              check_end;

  // seen_now includes lanes pulsing in the current cycle, so the check can end
  // on the very edge that follows the last lane_done pulse.
  assign seen_now  = seen_q | lane_done_w;
  assign start_acc = (top_q == T_IDLE) && start;
  assign check_end = (top_q == T_RUN) && (seen_now == ALL_LANES);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0]         st_q;
    logic [WIDTH-1:0]   mp_q, mp_d;
    logic [2*WIDTH-1:0] mc_q, acc_q, acc_d, prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               pulse_q;
    logic               last_w;

    always_comb begin
      acc_d = acc_q + (mp_q[0] ? mc_q : '0);
      mp_d  = mp_q >> 1;
      // Constant-time lanes always run WIDTH iterations; early-exit lanes stop
      // once no set multiplier bits remain after this iteration's shift.
      if (CT_MODE != 0) begin
        last_w = (cnt_q == CNT_W'(WIDTH - 1));
      end else begin
        last_w = (mp_d == '0);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q    <= L_IDLE;
        mp_q    <= '0;
        mc_q    <= '0;
        acc_q   <= '0;
        cnt_q   <= '0;
        prod_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (st_q)
          L_IDLE: begin
            if (start_acc) begin
              mp_q  <= multiplier[i*WIDTH +: WIDTH];
              mc_q  <= {{WIDTH{1'b0}}, multiplicand[i*WIDTH +: WIDTH]};
              acc_q <= '0;
              cnt_q <= '0;
              st_q  <= L_RUN;
            end
          end
          L_RUN: begin
            acc_q <= acc_d;
            mc_q  <= mc_q << 1;
            mp_q  <= mp_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_w) begin
              prod_q  <= acc_d;
              pulse_q <= 1'b1;
              st_q    <= L_DONE;
            end
          end
          L_DONE: begin
            if (check_end) begin
              st_q <= L_IDLE;
            end
          end
          default: st_q <= L_IDLE;
        endcase
      end
    end

    assign product[i*2*WIDTH +: 2*WIDTH] = prod_q;
    assign lane_done_w[i]                = pulse_q;
  end

  always_comb begin
    top_d   = top_q;
    busy_d  = busy_q;
    leak_d  = leak_q;
    first_d = first_q;
    skew_d  = skew_q;
    seen_d  = seen_q;
    cdone_d = 1'b0;
    case (top_q)
      T_IDLE: begin
        if (start) begin
          top_d   = T_RUN;
          busy_d  = 1'b1;
          leak_d  = 1'b0;
          first_d = '0;
          skew_d  = '0;
          seen_d  = '0;
        end
      end
      T_RUN: begin
        seen_d = seen_now;
        // A completion while some lane is still running means the lanes disagree.
        if ((lane_done_w != '0) && (seen_now != ALL_LANES)) begin
          leak_d = 1'b1;
        end
        if ((seen_q == '0) && (lane_done_w != '0)) begin
          first_d = lane_done_w;
        end
        // Count every cycle after the first completion cycle, through the last one.
        if ((seen_q != '0) && (skew_q != SKEW_MAX)) begin
          skew_d = skew_q + SKEW_W'(1);
        end
        if (seen_now == ALL_LANES) begin
          top_d   = T_FINISH;
          busy_d  = 1'b0;
          cdone_d = 1'b1;
        end
      end
      T_FINISH: top_d = T_IDLE;
      default:  top_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q   <= T_IDLE;
      busy_q  <= 1'b0;
      leak_q  <= 1'b0;
      first_q <= '0;
      skew_q  <= '0;
      seen_q  <= '0;
      cdone_q <= 1'b0;
    end else begin
      top_q   <= top_d;
      busy_q  <= busy_d;
      leak_q  <= leak_d;
      first_q <= first_d;
      skew_q  <= skew_d;
      seen_q  <= seen_d;
      cdone_q <= cdone_d;
    end
  end

  assign lane_done   = lane_done_w;
  assign busy        = busy_q;
  assign timing_leak = leak_q;
  assign first_mask  = first_q;
  assign skew        = skew_q;
  assign check_done  = cdone_q;

endmodule

// File: tb/tb_mult_timing_leak_monitor.sv
// tb/tb_mult_timing_leak_monitor.sv - self-checking bench for mult_timing_leak_monitor
module tb_mult_timing_leak_monitor;

  typedef struct {
    int              dut;
    logic [2:0][7:0] mp;
    logic [2:0][7:0] mc;
    logic [2:0][15:0] prod;
    logic            leak;
    logic [2:0]      first;
    int              skew;
    logic [2:0][7:0] dcyc;
    int              cdone;
    logic            rep;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: W=8 L=2 constant-time; dut1: W=8 L=3 early-exit; dut2: W=8 L=2 early-exit, SKEW_W=2
  logic        st0, st1, st2;
  logic [15:0] mp0, mc0, mp2, mc2;
  logic [23:0] mp1, mc1;
  logic [31:0] prod0, prod2;
  logic [47:0] prod1;
  logic [1:0]  ld0, ld2, first0, first2;
  logic [2:0]  ld1, first1;
  logic        busy0, busy1, busy2, leak0, leak1, leak2, cd0, cd1, cd2;
  logic [15:0] skew0, skew1;
  logic [1:0]  skew2;

  mult_timing_leak_monitor #(.WIDTH(8), .LANES(2), .CT_MODE(1), .SKEW_W(16)) u_ct (
    .clk(clk), .rst(rst), .start(st0), .multiplier(mp0), .multiplicand(mc0),
    .product(prod0), .lane_done(ld0), .busy(busy0), .timing_leak(leak0),
    .first_mask(first0), .skew(skew0), .check_done(cd0));

  mult_timing_leak_monitor #(.WIDTH(8), .LANES(3), .CT_MODE(0), .SKEW_W(16)) u_ee (
    .clk(clk), .rst(rst), .start(st1), .multiplier(mp1), .multiplicand(mc1),
    .product(prod1), .lane_done(ld1), .busy(busy1), .timing_leak(leak1),
    .first_mask(first1), .skew(skew1), .check_done(cd1));

  mult_timing_leak_monitor #(.WIDTH(8), .LANES(2), .CT_MODE(0), .SKEW_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(st2), .multiplier(mp2), .multiplicand(mc2),
    .product(prod2), .lane_done(ld2), .busy(busy2), .timing_leak(leak2),
    .first_mask(first2), .skew(skew2), .check_done(cd2));

  int               sel;
  logic [2:0]       obs_ld, obs_first;
  logic [2:0][15:0] obs_prod;
  logic             obs_busy, obs_leak, obs_cd;
  logic [15:0]      obs_skew;

  always_comb begin
    obs_ld = '0; obs_first = '0; obs_prod = '0; obs_busy = 1'b0;
    obs_leak = 1'b0; obs_cd = 1'b0; obs_skew = '0;
    case (sel)
      0: begin
        obs_ld = {1'b0, ld0}; obs_first = {1'b0, first0}; obs_prod = {16'h0, prod0};
        obs_busy = busy0; obs_leak = leak0; obs_cd = cd0; obs_skew = skew0;
      end
      1: begin
        obs_ld = ld1; obs_first = first1; obs_prod = prod1;
        obs_busy = busy1; obs_leak = leak1; obs_cd = cd1; obs_skew = skew1;
      end
      2: begin
        obs_ld = {1'b0, ld2}; obs_first = {1'b0, first2}; obs_prod = {16'h0, prod2};
        obs_busy = busy2; obs_leak = leak2; obs_cd = cd2; obs_skew = {14'h0, skew2};
      end
      default: ;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic s, input logic [23:0] mp, input logic [23:0] mc);
    case (d)
      0: begin st0 = s; mp0 = mp[15:0]; mc0 = mc[15:0]; end
      1: begin st1 = s; mp1 = mp;       mc1 = mc;       end
      default: begin st2 = s; mp2 = mp[15:0]; mc2 = mc[15:0]; end
    endcase
  endtask

  function automatic vec_t mk(input int d,
      input int a0, input int a1, input int a2, input int b0, input int b1, input int b2,
      input int p0, input int p1, input int p2, input logic lk, input logic [2:0] fm,
      input int sk, input int d0, input int d1, input int d2, input int cdn, input logic rp);
    vec_t v;
    v.dut = d;
    v.mp[0] = 8'(a0); v.mp[1] = 8'(a1); v.mp[2] = 8'(a2);
    v.mc[0] = 8'(b0); v.mc[1] = 8'(b1); v.mc[2] = 8'(b2);
    v.prod[0] = 16'(p0); v.prod[1] = 16'(p1); v.prod[2] = 16'(p2);
    v.leak = lk; v.first = fm; v.skew = sk;
    v.dcyc[0] = 8'(d0); v.dcyc[1] = 8'(d1); v.dcyc[2] = 8'(d2);
    v.cdone = cdn; v.rep = rp;
    return v;
  endfunction

  // Reference: latency from iteration count, product by plain multiplication,
  // leak/first/skew from the spread of the per-lane completion cycles.
  function automatic vec_t model(input int d, input logic [2:0][7:0] mp, input logic [2:0][7:0] mc);
    vec_t v;
    int n, it, mn, mx, sat;
    v.dut = d; v.mp = mp; v.mc = mc; v.prod = '0; v.first = '0; v.dcyc = '0; v.rep = 1'b0;
    n   = (d == 1) ? 3 : 2;
    sat = (d == 2) ? 3 : 65535;
    mn  = 1000; mx = 0;
    for (int l = 0; l < n; l++) begin
      if (d == 0) it = 8;
      else begin
        it = 1;
        for (int b = 0; b < 8; b++) if (mp[l][b]) it = b + 1;
      end
      v.dcyc[l] = 8'(it + 1);
      v.prod[l] = 16'(mp[l]) * 16'(mc[l]);
      if (it + 1 < mn) mn = it + 1;
      if (it + 1 > mx) mx = it + 1;
    end
    for (int l = 0; l < n; l++) if (int'(v.dcyc[l]) == mn) v.first[l] = 1'b1;
    v.leak  = (mn != mx);
    v.skew  = (mx - mn > sat) ? sat : mx - mn;
    v.cdone = mx + 1;
    return v;
  endfunction

  // Start issued in cycle 0; cycle c is c edges after that.
  task automatic run_vec(input vec_t v);
    int   pc[3];
    int   pn[3];
    int   cdc, cdn;
    logic b_before, b_at;
    for (int l = 0; l < 3; l++) begin pc[l] = 0; pn[l] = 0; end
    cdc = 0; cdn = 0; b_before = 1'b0; b_at = 1'b1;
    sel = v.dut;
    drive(v.dut, 1'b1, v.mp, v.mc);
    tick();
    drive(v.dut, 1'b0, v.mp, v.mc);
    chk("busy_after_start", 64'(obs_busy), 64'd1);
    chk("leak_cleared_at_start", 64'(obs_leak), 64'd0);
    chk("first_cleared_at_start", 64'(obs_first), 64'd0);
    chk("skew_cleared_at_start", 64'(obs_skew), 64'd0);
    for (int c = 1; c <= 30; c++) begin
      for (int l = 0; l < 3; l++) if (obs_ld[l]) begin
        pn[l]++;
        if (pc[l] == 0) pc[l] = c;
      end
      if (obs_cd) begin
        cdn++;
        if (cdc == 0) cdc = c;
      end
      if (c == v.cdone - 1) b_before = obs_busy;
      if (c == v.cdone) b_at = obs_busy;
      if (v.rep && c == 4) drive(v.dut, 1'b1, ~v.mp, ~v.mc);
      if (v.rep && c == 5) drive(v.dut, 1'b0, ~v.mp, ~v.mc);
      tick();
    end
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("lane%0d_done_cycle", l), 64'(pc[l]), 64'(v.dcyc[l]));
      chk($sformatf("lane%0d_pulse_count", l), 64'(pn[l]), 64'(v.dcyc[l] != 0));
      chk($sformatf("lane%0d_product", l), 64'(obs_prod[l]), 64'(v.prod[l]));
    end
    chk("check_done_cycle", 64'(cdc), 64'(v.cdone));
    chk("check_done_count", 64'(cdn), 64'd1);
    chk("busy_before_end", 64'(b_before), 64'd1);
    chk("busy_at_check_done", 64'(b_at), 64'd0);
    chk("timing_leak", 64'(obs_leak), 64'(v.leak));
    chk("first_mask", 64'(obs_first), 64'(v.first));
    chk("skew", 64'(obs_skew), 64'(v.skew));
    chk("busy_idle", 64'(obs_busy), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lane_done"}, 64'(obs_ld), 64'd0);
    chk({tag, "_product"}, 64'(obs_prod), 64'd0);
    chk({tag, "_busy"}, 64'(obs_busy), 64'd0);
    chk({tag, "_leak"}, 64'(obs_leak), 64'd0);
    chk({tag, "_first"}, 64'(obs_first), 64'd0);
    chk({tag, "_skew"}, 64'(obs_skew), 64'd0);
    chk({tag, "_check_done"}, 64'(obs_cd), 64'd0);
  endtask

  vec_t tbl[9];

  initial begin
    vec_t            v;
    logic [2:0][7:0] rmp, rmc;
    int              rd;

    tbl[0] = mk(0, 3, 255, 0, 5, 255, 0, 15, 65025, 0, 1'b0, 3'b011, 0, 9, 9, 0, 10, 1'b0);
    tbl[1] = mk(1, 1, 8'h80, 8'h0F, 7, 7, 7, 7, 896, 105, 1'b1, 3'b001, 7, 2, 9, 5, 10, 1'b0);
    tbl[2] = mk(1, 8'h10, 8'h1F, 8'h11, 3, 4, 5, 48, 124, 85, 1'b0, 3'b111, 0, 6, 6, 6, 7, 1'b1);
    tbl[3] = mk(1, 0, 0, 0, 9, 3, 200, 0, 0, 0, 1'b0, 3'b111, 0, 2, 2, 2, 3, 1'b0);
    tbl[4] = mk(2, 1, 8'h80, 0, 2, 3, 0, 2, 384, 0, 1'b1, 3'b001, 3, 2, 9, 0, 10, 1'b0);
    tbl[5] = mk(0, 0, 1, 0, 255, 255, 0, 0, 255, 0, 1'b0, 3'b011, 0, 9, 9, 0, 10, 1'b1);
    tbl[6] = mk(2, 0, 0, 0, 5, 6, 0, 0, 0, 0, 1'b0, 3'b011, 0, 2, 2, 0, 3, 1'b0);
    tbl[7] = mk(1, 2, 1, 8'h40, 10, 20, 30, 20, 20, 1920, 1'b1, 3'b010, 6, 3, 2, 8, 9, 1'b0);
    tbl[8] = mk(0, 8'h0A, 8'h33, 0, 8'h11, 2, 0, 170, 102, 0, 1'b0, 3'b011, 0, 9, 9, 0, 10, 1'b0);

    rst = 1'b1; sel = 0;
    drive(0, 1'b0, '0, '0); drive(1, 1'b0, '0, '0); drive(2, 1'b0, '0, '0);
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      chk_zero($sformatf("reset_dut%0d", d));
    end
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) run_vec(tbl[k]);

    // Reset mid-run: start in cycle 0, rst sampled at the end of cycle 5.
    sel = 0;
    drive(0, 1'b1, 24'h00_C8_64, 24'h00_FF_FF);
    tick();
    drive(0, 1'b0, 24'h00_C8_64, 24'h00_FF_FF);
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("midrun_reset");
    for (int c = 6; c < 8; c++) begin
      chk("post_reset_no_lane_done", 64'(obs_ld), 64'd0);
      chk("post_reset_no_check_done", 64'(obs_cd), 64'd0);
      tick();
    end
    run_vec(tbl[8]);

    for (int k = 0; k < 45; k++) begin
      rd = $urandom_range(0, 2);
      for (int l = 0; l < 3; l++) begin
        rmp[l] = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
        rmc[l] = 8'($urandom_range(0, 255));
      end
      v = model(rd, rmp, rmc);
      v.rep = ($urandom_range(0, 3) == 0);
      run_vec(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_timing_leak_monitor.md
Name: mult_timing_leak_monitor

Overview:
- N-lane timing side-channel checker for sequential multipliers. The two-copy tester generalises to LANES parallel shift-add multiplier lanes that share one start.
- A monitor compares when each lane completes. It latches a sticky leak flag, records which lanes finished first, and measures the first-to-last completion skew in cycles.
- Used in formal and simulation harnesses to prove the constant-time mode is leak-free and that the early-exit mode is caught.

Parameters:
- WIDTH, 1024, operand width per lane; the product is 2*WIDTH.
- LANES, 2, number of multiplier lanes, >=2.
- CT_MODE, 1, 1 = constant-time (always WIDTH iterations); 0 = early-exit (data-dependent iterations).
- SKEW_W, 16, width of the skew counter; it saturates.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  start request; sampled only when idle.
- multiplier  in  LANES*WIDTH  packed operands; lane i uses bits [i*WIDTH +: WIDTH].
- multiplicand  in  LANES*WIDTH  packed, same layout.
- product  out  LANES*2*WIDTH  packed results; lane i uses [i*2*WIDTH +: 2*WIDTH].
- lane_done  out  LANES  per-lane completion pulse.
- busy  out  1  high from start acceptance until check_done.
- timing_leak  out  1  sticky; high if lanes did not all complete in the same cycle.
- first_mask  out  LANES  lanes that pulsed in the earliest completion cycle.
- skew  out  SKEW_W  cycles from the first lane_done to the last lane_done.
- check_done  out  1  one-cycle pulse marking the end of the check.

Behaviour:
- Reset (synchronous, active-high):
  - Clears all lane state and all outputs to 0: product, lane_done, busy, timing_leak, first_mask, skew, check_done.
  - Reset mid-operation aborts every lane. No lane_done or check_done pulses follow.
- Top FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 moves to RUN on the next edge.
  - On that edge every lane loads its operands, the accumulator clears to 0, and the iteration count clears to 0.
  - busy rises on that edge. timing_leak, first_mask and skew clear on that edge.
- start while busy is ignored: operands are not reloaded and there is no effect.
- Lane FSM states: IDLE, RUN, DONE. In each RUN cycle the lane does:
  - if the multiplier lsb is 1, acc += shifted multiplicand (2*WIDTH bits, no overflow possible);
  - shifted multiplicand shifts left by 1;
  - remaining multiplier shifts right by 1;
  - count increments.
- Lane termination:
  - CT_MODE=1: the last RUN cycle is count==WIDTH-1, so WIDTH iterations regardless of data.
  - CT_MODE=0: the last RUN cycle is the first in which the post-shift remaining multiplier is 0. Iterations = max(1, msb_index+1); multiplier==0 gives 1 iteration.
- Lane completion:
  - On the edge ending the last RUN cycle, the lane writes acc to its product slice and enters DONE.
  - lane_done[i] is high for exactly one cycle, the first cycle in DONE. CT latency = WIDTH+1 cycles from the edge that sampled start.
  - A lane stays in DONE, without further pulses, until the check ends.
- Monitor, while busy:
  - Any cycle where lane_done is nonzero but not all lanes have finished → timing_leak=1 (sticky until next accepted start or rst).
  - The first cycle with lane_done nonzero captures first_mask = lane_done. first_mask is captured once per check.
  - skew increments every cycle after the first completion cycle, up to and including the last completion cycle, saturating at 2^SKEW_W-1.
  - All lanes completing in the same cycle gives skew=0 and timing_leak=0.
- When all lanes have done, the top FSM enters FINISH:
  - check_done pulses for one cycle, the cycle after the last lane_done pulse;
  - busy drops on the same edge;
  - all lanes return to IDLE.
- The FSM returns to IDLE the next cycle. start is accepted in the cycle check_done is high only if the FSM is already IDLE; otherwise it waits.
- Products, timing_leak, first_mask and skew hold until the next accepted start or rst.

Test Plan:
- WIDTH=8, LANES=2, CT_MODE=1, lane0=3*5, lane1=255*255, start at cycle 0:
  - both lane_done pulse at cycle 9; products 15 and 65025;
  - timing_leak=0, skew=0, first_mask=2'b11;
  - check_done at cycle 10.
- WIDTH=8, LANES=3, CT_MODE=0, multipliers 1, 0x80, 0x0F, multiplicands all 7:
  - lane_done for lane0 at cycle 2, lane2 at cycle 5, lane1 at cycle 9;
  - timing_leak=1, first_mask=3'b001, skew=7;
  - products 7, 896, 105; check_done at cycle 10.
- CT_MODE=0, both multipliers 0 → both pulse at cycle 2; products 0; timing_leak=0, skew=0.
- Run 1 leaks, then run 2 uses equal-latency operands → timing_leak clears at the run-2 start edge and stays 0.
  - Also: start re-pulsed at cycle 4 during a run has no effect on products or timing.
- rst at cycle 5 mid-run:
  - all outputs are 0 at cycle 6 and no lane_done or check_done follows;
  - a new start at cycle 8 completes normally with CT latency.
- SKEW_W=2, CT_MODE=0, multipliers 1 and 0x80 → skew saturates at 3; timing_leak=1.
